// File: rtl/dm_responder.sv
// dm_responder: MEM-stage data-memory target; one request at a time, WAIT_CYCLES latency, stall + response strobe.
// Optional macro DM_ALIGN_CHECK_EN enables misalignment detection (misalign_err); otherwise low address bits are ignored.
module dm_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  DMWr,
  input  logic [3:0]  DMRd,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        mem_stall,
  output logic        misalign_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      wr_q;
  logic [3:0]      rd_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic            mis_q;
  logic [31:0]     mem_q [DEPTH_WORDS];

  logic            in_idle;
  logic            rd_legal;
  logic            accept;
  logic [1:0]      op_wr;
  logic [3:0]      op_rd;
  logic [AW+1:0]   op_addr;
  logic [31:0]     op_wdata;
  logic [31:0]     word;
  logic [15:0]     lhalf;
  logic [7:0]      lbyte;
  logic [31:0]     wmerge;
  logic [31:0]     ldata;
  logic            mis;
  logic            commit;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^addr[31:AW+2];

  assign in_idle  = (state_q == S_IDLE);
  assign rd_legal = (DMRd >= 4'd1) && (DMRd <= 4'd5);
  assign accept   = in_idle && req_valid && ((DMWr != 2'b00) || rd_legal);

  // In IDLE the access is evaluated from the live request so a zero-wait response can be registered on the accept edge
  assign op_wr    = in_idle ? DMWr            : wr_q;
  assign op_rd    = in_idle ? DMRd            : rd_q;
  assign op_addr  = in_idle ? addr[AW+1:0]    : addr_q;
  assign op_wdata = in_idle ? wdata           : wdata_q;

  assign word  = mem_q[op_addr[AW+1:2]];
  assign lhalf = op_addr[1] ? word[31:16] : word[15:0];
  assign lbyte = word[{op_addr[1:0], 3'b000} +: 8];

`ifdef DM_ALIGN_CHECK_EN
  always_comb begin
    mis = 1'b0;
    if ((op_wr == 2'b01) || ((op_wr == 2'b00) && (op_rd == 4'd1)))
      mis = (op_addr[1:0] != 2'b00);
    else if ((op_wr == 2'b10) || ((op_wr == 2'b00) && ((op_rd == 4'd2) || (op_rd == 4'd3))))
      mis = op_addr[0];
  end
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    wmerge = word;
    case (op_wr)
      2'b01: wmerge = op_wdata;
      2'b10: begin
        if (op_addr[1]) wmerge[31:16] = op_wdata[15:0];
        else            wmerge[15:0]  = op_wdata[15:0];
      end
      2'b11: wmerge[{op_addr[1:0], 3'b000} +: 8] = op_wdata[7:0];
      default: wmerge = word;
    endcase
  end

  always_comb begin
    ldata = 32'h0;
    case (op_rd)
      4'd1: ldata = word;
      4'd2: ldata = {{16{lhalf[15]}}, lhalf};
      4'd3: ldata = {16'h0, lhalf};
      4'd4: ldata = {{24{lbyte[7]}}, lbyte};
      4'd5: ldata = {24'h0, lbyte};
      default: ldata = 32'h0;
    endcase
    if ((op_wr != 2'b00) || mis) ldata = 32'h0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d   = CW'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 2'b00;
      rd_q    <= 4'h0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= DMWr;
        rd_q    <= DMRd;
        addr_q  <= addr[AW+1:0];
        wdata_q <= wdata;
      end
      if (state_d == S_RESP) begin
        rdata_q <= ldata;
        mis_q   <= mis;
      end
    end
  end

  // A reset during WAIT/RESP leaves state_q in IDLE, so a pending store never reaches this commit
  assign commit = (state_q == S_RESP) && (wr_q != 2'b00) && !mis_q;

  always_ff @(posedge clk) begin
    if (commit) mem_q[addr_q[AW+1:2]] <= wmerge;
  end

  assign req_ready    = in_idle;
  assign rsp_valid    = (state_q == S_RESP);
  assign mem_stall    = accept || (state_q == S_WAIT);
  assign misalign_err = rsp_valid && mis_q;
  assign rdata        = rdata_q;

endmodule
